// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state type,
// default fairness/timeout limits and the byte-lane decode helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 16;

  function automatic logic [3:0] byte_lane(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// favouring data accesses but bounding how long fetch can be starved.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 2);
  localparam int unsigned WW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [SW-1:0] r_starve;
  logic [WW-1:0] r_wait;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic          w_gnt_i;
  logic          w_gnt_d;
  logic          w_timeout;
  logic          w_fin;
  logic          w_unused_rdata;

  // Read data is routed straight to the requesters; nothing here consumes it.
  assign w_unused_rdata = ^mem_rdata;

  assign w_gnt_d   = (r_state == IDLE) && d_req && (!i_req || (r_starve < STARVE_LIM));
  assign w_gnt_i   = (r_state == IDLE) && !w_gnt_d && i_req;
  assign w_timeout = (r_state != IDLE) && !mem_ready && (r_wait == WAIT_LAST);
  // Reset in the same cycle as completion suppresses the ack entirely.
  assign w_fin     = !rst && (mem_ready || w_timeout);

  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_d)      w_next = GNT_D;
        else if (w_gnt_i) w_next = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (mem_ready || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      GNT_I: begin
        mem_req     = 1'b1;
        i_ack       = w_fin;
        timeout_err = w_fin && !mem_ready;
      end
      GNT_D: begin
        mem_req     = 1'b1;
        mem_we      = r_we;
        d_ack       = w_fin;
        timeout_err = w_fin && !mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_wait   <= '0;
      r_starve <= '0;
    end else begin
      if (w_gnt_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_be    <= d_byte ? byte_lane(d_addr[1:0]) : '1;
        r_wdata <= d_byte ? {4{d_wdata[7:0]}} : d_wdata;
      end else if (w_gnt_i) begin
        r_addr  <= i_addr;
        r_we    <= 1'b0;
        r_be    <= '1;
        r_wdata <= '0;
      end

      if (w_gnt_d || w_gnt_i)
        r_wait <= '0;
      else if ((r_state != IDLE) && !mem_ready && !w_timeout)
        r_wait <= r_wait + WW'(1);

      if (r_state == IDLE) begin
        if (!i_req || w_gnt_i)
          r_starve <= '0;
        else if (w_gnt_d && (r_starve < STARVE_LIM))
          r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule
